pipelined_adder_sub: RTL

//  - Parametrised, pipelined N-bit add/subtract unit. Successor to the single-cycle carry-lookahead-style adder.
//  - Operand width is split into STAGES equal chunks, one chunk resolved per stage; carry ripples stage to stage.
//  - valid/ready handshake on both sides; emits carry, signed overflow, zero and negative flags.
//  - Used for multi-cycle ALU extensions and address arithmetic where the single-cycle adder limits Fmax.

---
 rtl/pipelined_adder_sub_if.sv | 28 ++
 rtl/pipelined_adder_sub.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pipelined_adder_sub_if.sv
// rtl/pipelined_adder_sub_if.sv - operand/result handshake bundle for pipelined_adder_sub
interface pipelined_adder_sub_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, carry, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, carry, overflow, zero, negative
    );
endinterface

// File: rtl/pipelined_adder_sub.sv
// rtl/pipelined_adder_sub.sv - STAGES-deep chunked add/sub pipeline; PIPE_ADDER_SAT_EN adds signed saturation
module pipelined_adder_sub #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_adder_sub_if.slave   bus
);
    localparam int CHUNK = N / STAGES;
    localparam int OPS   = (STAGES > 1) ? STAGES - 1 : 1;

    logic [STAGES-1:0] v;
    logic [STAGES:0]   ld;

    logic [N-1:0] res_q [OPS];
    logic [N-1:0] opa_q [OPS];
    logic [N-1:0] opb_q [OPS];
    logic         cy_q  [OPS];

    logic [N-1:0] st_a [STAGES];
    logic [N-1:0] st_b [STAGES];
    logic [N-1:0] st_r [STAGES];
    logic         st_c [STAGES];
    logic         st_v [STAGES];

    logic [N-1:0] sum_q;
    logic         carry_q;
    logic         ovf_q;
    logic         zero_q;
    logic         neg_q;

    // A stage may load when empty or when its successor is loading this cycle.
    assign ld[STAGES] = bus.out_ready;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [CHUNK:0] part;
            logic [N-1:0]   res_d;

            assign ld[k] = !v[k] | ld[k+1];

            if (k == 0) begin : g_first
                assign st_a[k] = bus.a;
                assign st_b[k] = bus.sub ? ~bus.b : bus.b;
                assign st_c[k] = bus.sub | bus.cin;
                assign st_r[k] = '0;
                assign st_v[k] = bus.in_valid;
            end else begin : g_next
                assign st_a[k] = opa_q[k-1];
                assign st_b[k] = opb_q[k-1];
                assign st_c[k] = cy_q[k-1];
                assign st_r[k] = res_q[k-1];
                assign st_v[k] = v[k-1];
            end

            assign part = {1'b0, st_a[k][k*CHUNK +: CHUNK]}
                        + {1'b0, st_b[k][k*CHUNK +: CHUNK]}
                        + {{CHUNK{1'b0}}, st_c[k]};

            always_comb begin
                res_d = st_r[k];
                res_d[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            end

            if (k < STAGES - 1) begin : g_mid
                // Data only moves with a valid op so empty stages hold their last contents.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        res_q[k] <= '0;
                        opa_q[k] <= '0;
                        opb_q[k] <= '0;
                        cy_q[k]  <= 1'b0;
                    end else if (ld[k] && st_v[k]) begin
                        res_q[k] <= res_d;
                        opa_q[k] <= st_a[k];
                        opb_q[k] <= st_b[k];
                        cy_q[k]  <= part[CHUNK];
                    end
                end
            end else begin : g_last
                logic [N-1:0] fin_sum;
                logic         fin_ovf;

                assign fin_ovf = (st_a[k][N-1] == st_b[k][N-1]) && (res_d[N-1] != st_a[k][N-1]);
`ifdef PIPE_ADDER_SAT_EN
                assign fin_sum = !fin_ovf     ? res_d :
                                 st_a[k][N-1] ? {1'b1, {(N-1){1'b0}}} :
                                                {1'b0, {(N-1){1'b1}}};
`else
                assign fin_sum = res_d;
`endif

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sum_q   <= '0;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        zero_q  <= 1'b0;
                        neg_q   <= 1'b0;
                    end else if (ld[k] && st_v[k]) begin
                        sum_q   <= fin_sum;
                        carry_q <= part[CHUNK];
                        ovf_q   <= fin_ovf;
                        zero_q  <= (fin_sum == '0);
                        neg_q   <= fin_sum[N-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (ld[i]) v[i] <= st_v[i];
            end
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
endmodule
